// File: rtl/noc_input_buffer.sv
// ---------------------------------------------------------------------------
// noc_input_buffer
//
// Purpose:
//   Credit-based NoC router input buffer. Flits from an upstream link are
//   stored in a DEPTH-entry circular buffer and presented head-first to the
//   downstream consumer. Every consumed flit returns one credit upstream as
//   a single-cycle pulse in the following cycle. Protocol violations
//   (overflow while full, or consume while empty) are ignored functionally
//   and recorded in a sticky error flag.
//
// Ports:
//   clk       in   1           sole clock, rising edge
//   reset     in   1           asynchronous active-high reset
//   valid_i   in   1           flit present on data_i
//   data_i    in   DATA_WIDTH  incoming flit payload
//   valid_o   out  1           buffer non-empty, data_o is the head flit
//   data_o    out  DATA_WIDTH  head flit, combinational read of storage
//   yumi_i    in   1           downstream consumes the head flit this cycle
//   credit_o  out  1           one-cycle credit-return pulse
//   count_o   out  3           current occupancy, 0..DEPTH
//   err_o     out  1           sticky protocol-violation flag
// ---------------------------------------------------------------------------
module noc_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  yumi_i,
    output logic                  credit_o,
    output logic [2:0]            count_o,
    output logic                  err_o
);

    // Pointer width; at least one bit so a single-entry buffer still elaborates.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Constants sized to their comparison partners to keep widths matched.
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_CNT = 3'(DEPTH);

    // Storage is deliberately left out of reset: only pointers and count
    // decide what is valid, so stale contents are never observed.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [2:0]    r_count;
    logic          r_credit;
    logic          r_err;

    logic          w_empty;
    logic          w_full;
    logic          w_deq;
    logic          w_enq;
    logic          w_overflow;
    logic          w_underflow;
    logic [PW-1:0] w_rd_ptr_inc;
    logic [PW-1:0] w_wr_ptr_inc;
    logic [2:0]    w_count_next;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == DEPTH_CNT);

    // A dequeue frees a slot in the same cycle, so a full buffer can still
    // accept a flit when the head is consumed alongside it.
    assign w_deq       = yumi_i && !w_empty;
    assign w_enq       = valid_i && (!w_full || w_deq);
    assign w_overflow  = valid_i && w_full && !w_deq;
    assign w_underflow = yumi_i && w_empty;

    // Explicit wrap because DEPTH need not be a power of two.
    assign w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_next = r_count + 3'd1;
            2'b01:   w_count_next = r_count - 3'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 3'd0;
            r_credit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_deq) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_enq) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            r_count  <= w_count_next;
            // Credit follows the accepted dequeue by exactly one cycle.
            r_credit <= w_deq;
            if (w_overflow || w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign valid_o  = !w_empty;
    assign data_o   = r_mem[r_rd_ptr];
    assign credit_o = r_credit;
    assign count_o  = r_count;
    assign err_o    = r_err;

endmodule

// File: tb/tb_noc_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_noc_input_buffer
//
// Self-checking bench for noc_input_buffer. A queue-based model tracks the
// buffered flits, the pending credit and the sticky error. A compare process
// checks every DUT output against the model on each falling edge; directed
// sequences add literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_noc_input_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 5;

    logic          clk;
    logic          reset;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          yumi_i;
    logic          credit_o;
    logic [2:0]    count_o;
    logic          err_o;

    noc_input_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i),
        .credit_o (credit_o),
        .count_o  (count_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [DW-1:0] m_q[$];
    logic          m_credit;
    logic          m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_credit = 1'b0;
        m_err    = 1'b0;
    endtask

    // Drive one cycle of inputs from a falling edge, update the model from
    // the pre-edge state at the rising edge, and return at the next falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic y);
        bit deq;
        bit enq;
        valid_i = v;
        data_i  = d;
        yumi_i  = y;
        @(posedge clk);
        deq = y && (m_q.size() > 0);
        enq = v && ((m_q.size() < DEPTH) || deq);
        if ((v && m_q.size() == DEPTH && !deq) || (y && m_q.size() == 0))
            m_err = 1'b1;
        m_credit = deq;
        if (deq) void'(m_q.pop_front());
        if (enq) m_q.push_back(d);
        @(negedge clk);
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        $display("cycle t=%0t v=%0b d=0x%0h y=%0b -> cnt=%0d valid=%0b head=0x%0h credit=%0b err=%0b",
                 $time, v, d, y, count_o, valid_o, data_o, credit_o, err_o);
    endtask

    // Reset asserted just after a falling edge, checked asynchronously,
    // released on a later falling edge.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_clear();
        chk("rst_count",  {29'd0, count_o}, 32'd0);
        chk("rst_valid",  {31'd0, valid_o}, 32'd0);
        chk("rst_credit", {31'd0, credit_o}, 32'd0);
        chk("rst_err",    {31'd0, err_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_11_15();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h11 + i, 1'b0);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_count",  {29'd0, count_o}, 32'(m_q.size()));
            chk("cmp_valid",  {31'd0, valid_o}, {31'd0, (m_q.size() > 0)});
            if (m_q.size() > 0)
                chk("cmp_data", data_o, m_q[0]);
            chk("cmp_credit", {31'd0, credit_o}, {31'd0, m_credit});
            chk("cmp_err",    {31'd0, err_o}, {31'd0, m_err});
        end
    end

    initial begin
        int credits_seen;
        reset   = 1'b1;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        model_clear();
        @(negedge clk);
        apply_reset();

        // Fill from empty: no credits, head is the first flit
        credits_seen = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h11 + i, 1'b0);
            if (credit_o) credits_seen++;
        end
        chk("fill_count", {29'd0, count_o}, 32'd5);
        chk("fill_valid", {31'd0, valid_o}, 32'd1);
        chk("fill_head",  data_o, 32'h11);
        chk("fill_nocredit", 32'(credits_seen), 32'd0);
        chk("fill_err",   {31'd0, err_o}, 32'd0);

        // Drain: in-order heads, a credit after each dequeue
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", data_o, 32'h11 + i);
            step(1'b0, '0, 1'b1);
            chk("drain_credit", {31'd0, credit_o}, 32'd1);
        end
        chk("drain_count", {29'd0, count_o}, 32'd0);
        chk("drain_valid", {31'd0, valid_o}, 32'd0);
        step(1'b0, '0, 1'b0);
        chk("drain_credit_end", {31'd0, credit_o}, 32'd0);

        // Simultaneous enqueue/dequeue at full
        fill_11_15();
        step(1'b1, 32'h16, 1'b1);
        chk("full_both_count",  {29'd0, count_o}, 32'd5);
        chk("full_both_head",   data_o, 32'h12);
        chk("full_both_credit", {31'd0, credit_o}, 32'd1);
        chk("full_both_err",    {31'd0, err_o}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("full_both_order", data_o, (i == DEPTH - 1) ? 32'h16 : 32'h12 + i);
            step(1'b0, '0, 1'b1);
        end

        // Overflow: dropped, sticky error, drain is unaffected
        fill_11_15();
        step(1'b1, 32'h99, 1'b0);
        chk("ovf_count", {29'd0, count_o}, 32'd5);
        chk("ovf_err",   {31'd0, err_o}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_order", data_o, 32'h11 + i);
            step(1'b0, '0, 1'b1);
        end
        chk("ovf_empty", {29'd0, count_o}, 32'd0);
        chk("ovf_sticky", {31'd0, err_o}, 32'd1);

        // Underflow
        apply_reset();
        step(1'b0, '0, 1'b1);
        chk("udf_count",  {29'd0, count_o}, 32'd0);
        chk("udf_credit", {31'd0, credit_o}, 32'd0);
        chk("udf_err",    {31'd0, err_o}, 32'd1);
        step(1'b1, 32'h21, 1'b0);
        chk("udf_head", data_o, 32'h21);
        step(1'b0, '0, 1'b1);
        chk("udf_recover_credit", {31'd0, credit_o}, 32'd1);
        chk("udf_recover_count",  {29'd0, count_o}, 32'd0);

        // Reset mid-operation: 3 held, dequeue in the previous cycle
        step(1'b1, 32'h41, 1'b0);
        step(1'b1, 32'h42, 1'b0);
        step(1'b1, 32'h43, 1'b0);
        step(1'b1, 32'h44, 1'b1);
        chk("pre_rst_credit", {31'd0, credit_o}, 32'd1);
        chk("pre_rst_count",  {29'd0, count_o}, 32'd3);
        apply_reset();

        // Wrap: 7 enqueue/dequeue pairs pass the pointer wrap point
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 32'h30 + i, 1'b0);
            chk("wrap_head", data_o, 32'h30 + i);
            step(1'b0, '0, 1'b1);
            chk("wrap_credit", {31'd0, credit_o}, 32'd1);
        end

        // Randomized traffic, mostly legal with occasional violations
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            logic v;
            logic y;
            int sz;
            sz = m_q.size();
            y = ($urandom_range(0, 2) != 0) && (sz > 0);
            v = ($urandom_range(0, 3) != 0) && ((sz < DEPTH) || y);
            if ($urandom_range(0, 99) < 2) y = 1'b1;
            if ($urandom_range(0, 99) < 2) v = 1'b1;
            step(v, $urandom, y);
            if (n == 1000) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_input_buffer.md
NOC_INPUT_BUFFER -- requirements
Module: noc_input_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: flit payload width in bits.
REQ-002 Parameter DEPTH, default 5: buffer slots; SHALL equal the upstream credit counter's reset value.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  flit present on data_i this cycle; upstream sends only while it holds a credit.
REQ-006 data_i  input  DATA_WIDTH  incoming flit payload.
REQ-007 valid_o  output  1  buffer non-empty; data_o holds the head flit.
REQ-008 data_o  output  DATA_WIDTH  head flit, driven combinationally from storage.
REQ-009 yumi_i  input  1  downstream consumes the head flit this cycle; legal only while valid_o=1.
REQ-010 credit_o  output  1  one-cycle credit-return pulse to the upstream counter's increment input.
REQ-011 count_o  output  3  current occupancy, 0..DEPTH.
REQ-012 err_o  output  1  sticky protocol-violation flag.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer with read pointer, write pointer and occupancy counter.
REQ-014 Pointers SHALL wrap from DEPTH-1 to 0. DEPTH is not restricted to a power of two.
REQ-015 Enqueue: valid_i=1 and (count_o<DEPTH or dequeue in the same cycle). data_i is written at the write pointer and the write pointer advances.
REQ-016 Dequeue: yumi_i=1 and count_o>0. The read pointer advances.
REQ-017 Occupancy:
- enqueue only: +1
- dequeue only: -1
- both in the same cycle: unchanged
- neither: unchanged
REQ-018 valid_o SHALL be 1 exactly when count_o>0. A flit written in cycle N is visible on data_o in cycle N+1 at the earliest.
REQ-019 Flits SHALL leave in arrival order, with no loss, duplication or corruption.
REQ-020 credit_o SHALL pulse high for exactly one cycle, in the cycle after each accepted dequeue. One credit per dequeued flit; back-to-back dequeues give back-to-back pulses.
REQ-021 Overflow: valid_i=1, count_o=DEPTH and no same-cycle dequeue. The flit SHALL be dropped, state SHALL NOT change, and err_o SHALL be set.
REQ-022 Underflow: yumi_i=1 with count_o=0. It SHALL be ignored, no credit SHALL be returned, and err_o SHALL be set.
REQ-023 err_o SHALL remain 1 until reset. Normal operation SHALL continue after an error.
REQ-024 At count_o=DEPTH, a simultaneous enqueue and dequeue SHALL be accepted: occupancy stays DEPTH, the incoming flit takes the freed slot, one credit is returned, and err_o is unchanged.

Reset
REQ-025 While reset=1, asynchronously:
- count_o=0, valid_o=0, credit_o=0, err_o=0
- both pointers = 0
REQ-026 Reset mid-operation SHALL discard all buffered flits and any pending credit pulse. Storage contents need not be cleared.
REQ-027 The first enqueue SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-028 Reset, then 5 consecutive valid_i with data 0x11..0x15, yumi_i=0 -> count_o=5, valid_o=1, data_o=0x11, credit_o never pulses, err_o=0.
REQ-029 From full (0x11..0x15), yumi_i=1 for 5 cycles -> data_o sequence 0x11,0x12,0x13,0x14,0x15; credit_o high in each of the 5 following cycles; count_o ends at 0, valid_o=0.
REQ-030 From full, valid_i=1 with 0x16 and yumi_i=1 in the same cycle -> count_o stays 5, next head 0x12, 0x16 dequeued last, one credit pulse, err_o=0.
REQ-031 From full, valid_i=1 with 0x99 and yumi_i=0 -> 0x99 dropped, count_o=5, err_o=1 and remains 1; subsequent drain yields 0x11..0x15 only.
REQ-032 Empty buffer, yumi_i=1 -> count_o=0, credit_o=0, err_o=1; a following valid_i of 0x21 then yumi_i gives data_o=0x21 and one credit pulse.
REQ-033 With 3 flits held and a dequeue in the previous cycle, assert reset -> credit_o, count_o and valid_o are 0 immediately; after release, wrap test (7 enqueue/dequeue pairs) preserves order.
